// File: rtl/arm_fetch.sv
// arm_fetch: sequential instruction fetch with single-outstanding req/ack port, prefetch FIFO and redirect flush.
// Optional ARM_FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module arm_fetch #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_we,
  input  logic [31:0] pc_in,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef ARM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic [1:0] {RUN, WAIT, DRAIN} state_e;
  state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [31:0] ins_q [FIFO_DEPTH];
  logic [31:0] ins_d [FIFO_DEPTH];
  logic [31:0] pcs_q [FIFO_DEPTH];
  logic [31:0] pcs_d [FIFO_DEPTH];
  logic pop, push, issue;
  always_comb begin
    pop        = cnt_q != '0 && inst_ready && !pc_we;
    cnt_pop    = cnt_q - CW'(pop);
    issue      = state_q == RUN && !pc_we && cnt_pop < CW'(FIFO_DEPTH);
    push       = state_q == WAIT && imem_ack && !pc_we;
    state_d    = issue ? WAIT :
                 state_q == WAIT ? (imem_ack ? RUN : pc_we ? DRAIN : WAIT) :
                 state_q == DRAIN ? (imem_ack ? RUN : DRAIN) : RUN;
    addr_d     = issue ? fetch_pc_q : addr_q;
    fetch_pc_d = pc_we ? {pc_in[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    cnt_d      = pc_we ? '0 : cnt_pop + CW'(push);
  end
  // Head lives in entry 0; the last valid head is kept rather than shifted out so inst holds.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      ins_d[i] = ins_q[i];
      pcs_d[i] = pcs_q[i];
      if (pop && i + 1 < int'(cnt_q)) begin
        ins_d[i] = ins_q[(i + 1) % FIFO_DEPTH];
        pcs_d[i] = pcs_q[(i + 1) % FIFO_DEPTH];
      end
      if (push && i == int'(cnt_pop)) begin
        ins_d[i] = imem_rdata;
        pcs_d[i] = fetch_pc_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ins_q[i] <= ins_d[i];
        pcs_q[i] <= pcs_d[i];
      end
    end
  end
  assign imem_req   = state_q != RUN;
  assign imem_addr  = addr_q;
  assign inst_valid = cnt_q != '0;
  assign inst       = ins_q[0];
  assign inst_pc    = pcs_q[0];
`ifdef ARM_FETCH_PERF_EN
  logic discard;
  logic [31:0] fetched_q, flushed_q;
  assign discard = imem_ack && ((state_q == WAIT && pc_we) || state_q == DRAIN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(push);
      flushed_q <= flushed_q + (pc_we ? 32'(cnt_q) : 32'd0) + 32'(discard);
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_arm_fetch.sv
// tb_arm_fetch: randomized and directed stimulus for arm_fetch checked against a queue-based fetch model.
module tb_arm_fetch;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 0, rst_n = 0, imem_req, imem_ack = 0, pc_we = 0, inst_valid, inst_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0, pc_in = 0, inst, inst_pc;
`ifdef ARM_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  always #5 clk = ~clk;
  arm_fetch #(.FIFO_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_we(pc_we), .pc_in(pc_in),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef ARM_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [63:0] held;
  logic [31:0] fpc, addr, m_fet, m_fl;
  logic busy, drain;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    q.delete();
    fpc = RPC; addr = RPC; busy = 0; drain = 0; held = '0; m_fet = 0; m_fl = 0;
  endtask
  // One clock of fetch behaviour: pop, then request/response bookkeeping, then redirect.
  task automatic mstep(input logic a, input logic [31:0] d, input logic w, input logic [31:0] p, input logic r);
    int n = q.size();
    if (n > 0 && r && !w) void'(q.pop_front());
    if (busy) begin
      if (a) begin
        if (!drain && !w) begin
          q.push_back({fpc, d});
          fpc += 4;
          m_fet++;
        end else m_fl++;
        busy = 0;
        drain = 0;
      end else if (w) drain = 1;
    end else if (!w && q.size() < D) begin
      busy = 1;
      addr = fpc;
    end
    if (w) begin
      m_fl += n;
      q.delete();
      fpc = {p[31:2], 2'b00};
    end
    if (q.size() > 0) held = q[0];
  endtask
  task automatic compare();
    logic [63:0] h;
    h = q.size() > 0 ? q[0] : held;
    check("req", 32'(imem_req), 32'(busy));
    check("addr", imem_addr, addr);
    check("valid", 32'(inst_valid), 32'(q.size() > 0));
    check("inst", inst, h[31:0]);
    check("inst_pc", inst_pc, h[63:32]);
`ifdef ARM_FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fet);
    check("perf_flushed", perf_flushed, m_fl);
`endif
  endtask
  task automatic cyc(input logic a, input logic [31:0] d, input logic w, input logic [31:0] p, input logic r);
    @(negedge clk);
    compare();
    imem_ack = a; imem_rdata = d; pc_we = w; pc_in = p; inst_ready = r;
    mstep(a, d, w, p, r);
  endtask
  task automatic run(input int n, input int ap, input int wp, input int rp);
    repeat (n) cyc(busy && $urandom_range(99) < ap, $urandom, $urandom_range(99) < wp, $urandom,
                   $urandom_range(99) < rp);
  endtask
  // Reset is asserted mid-cycle and released on a falling edge with a stray ack that must be ignored.
  task automatic do_reset(input bit cmp);
    @(negedge clk);
    if (cmp) compare();
    rst_n = 0; imem_ack = 0; pc_we = 0; inst_ready = 0;
    #1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_addr", imem_addr, RPC);
`ifdef ARM_FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 0);
    check("rst_perf_flushed", perf_flushed, 0);
`endif
    mreset();
    @(negedge clk);
    rst_n = 1; imem_ack = 1; imem_rdata = $urandom;
    mstep(1, imem_rdata, 0, 0, 0);
  endtask
  initial begin
    int k;
    do_reset(0);
    run(12, 100, 0, 100);
    // Backpressure fills the FIFO, then a single pop frees exactly one request.
    do_reset(1);
    run(30, 100, 0, 0);
    check("full_req", 32'(imem_req), 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("refill_req", 32'(imem_req), 1);
    check("refill_addr", imem_addr, 32'h10);
    run(6, 100, 0, 0);
    // Redirect while waiting on 0x8, ack arrives later.
    do_reset(1);
    for (k = 0; k < 50 && !(busy && addr == 32'h8); k++) cyc(busy, $urandom, 0, 0, 1);
    check("reach_wait8", 32'(busy && addr == 32'h8), 1);
    cyc(0, 0, 1, 32'h0000_1003, 1);
    cyc(0, 0, 0, 0, 1);
    check("hold_addr", imem_addr, 32'h8);
    cyc(0, 0, 0, 0, 1);
    cyc(1, $urandom, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("drain_valid", 32'(inst_valid), 0);
    cyc(1, 32'hCAFE_0001, 0, 0, 1);
    check("redir_addr", imem_addr, 32'h1000);
    cyc(0, 0, 0, 0, 0);
    check("redir_inst_pc", inst_pc, 32'h1000);
    check("redir_inst", inst, 32'hCAFE_0001);
    // Redirect coinciding with ack and pop.
    do_reset(1);
    for (k = 0; k < 50 && !(busy && q.size() >= 1); k++) cyc(busy, $urandom, 0, 0, 0);
    check("reach_ack_pop", 32'(busy && q.size() >= 1), 1);
    cyc(1, $urandom, 1, 32'h2000, 1);
    cyc(0, 0, 0, 0, 0);
    check("flush_valid", 32'(inst_valid), 0);
    cyc(0, 0, 0, 0, 0);
    check("flush_addr", imem_addr, 32'h2000);
    // Address wrap at the top of memory.
    cyc(1, $urandom, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h1234_5678, 0, 0, 0);
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    // Reset while waiting with two entries buffered.
    do_reset(1);
    for (k = 0; k < 40 && !(busy && q.size() == 2); k++) cyc(busy, $urandom, 0, 0, 0);
    check("reach_two", 32'(busy && q.size() == 2), 1);
    do_reset(1);
    cyc(0, 0, 0, 0, 0);
    check("rst_first_req", 32'(imem_req), 1);
    check("rst_first_addr", imem_addr, RPC);
    run(3000, 50, 4, 60);
    repeat (5) begin
      run(400, 70, 3, 40);
      do_reset(1);
    end
    run(200, 100, 0, 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
